// File: rtl/half_mul_arbiter.sv
// ---------------------------------------------------------------------------
// half_mul_arbiter
//
// Shares one half-precision multiplier core among NREQ requesters.
// A round-robin arbiter picks one valid requester, registers its operands
// onto core_a/core_b, waits LAT cycles for the core, then captures the
// core's raw sign/exponent/normalised fraction. It returns them on a
// valid/ready response channel tagged with the requester index.
//
// Parameters
//   NREQ  number of requesters (2..8)
//   LAT   core latency in cycles, core_a/core_b stable -> core outputs valid (1..15)
//   IDW   requester id width, $clog2(NREQ) (local)
//
// Ports
//   clk, rst_n            clock (rising edge), async active-low reset
//   req_valid/req_ready   per-requester handshake; req_ready is one-hot or zero
//   req_a/req_b           packed operands, requester i at [16i+15:16i]
//   rsp_valid/rsp_ready   response handshake
//   rsp_id                index of the requester that owns the response
//   rsp_sign/exp/frac     captured core outputs, passed through bit-exact
//   core_a/core_b         registered operands driven to the core
//   core_sign/exp/frac    core outputs
//   busy                  high whenever the FSM is not idle
//   grant_cnt             per-requester 16-bit accepted-request counters,
//                         present only when HALF_MUL_ARB_STATS_EN is defined
//
// Build option
//   HALF_MUL_ARB_STATS_EN  adds the grant_cnt output and its counters
// ---------------------------------------------------------------------------
module half_mul_arbiter #(
  parameter  int NREQ = 4,
  parameter  int LAT  = 1,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [16*NREQ-1:0]  req_a,
  input  logic [16*NREQ-1:0]  req_b,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [IDW-1:0]      rsp_id,
  output logic                rsp_sign,
  output logic [4:0]          rsp_exp,
  output logic [20:0]         rsp_frac,
  output logic [15:0]         core_a,
  output logic [15:0]         core_b,
  input  logic                core_sign,
  input  logic [4:0]          core_exp,
  input  logic [20:0]         core_frac,
  output logic                busy
`ifdef HALF_MUL_ARB_STATS_EN
  ,
  output logic [16*NREQ-1:0]  grant_cnt
`endif
);

  localparam int unsigned NREQ_U = NREQ;
  localparam logic [3:0]  LAT_W  = 4'(LAT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  // One extra bit so rr_ptr + offset can exceed NREQ-1 before wrapping.
  typedef logic [IDW:0] sum_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] rr_ptr_q;
  logic [IDW-1:0] id_q;
  logic [3:0]     cnt_q;

  logic           gnt_found;
  logic [IDW-1:0] gnt_idx;
  logic [IDW-1:0] rr_next;
  sum_t           scan_sum;
  logic [15:0]    sel_a, sel_b;

  logic           fire;
  logic           capture;
  logic           retire;

  // -------------------------------------------------------------------------
  // Round-robin scan: first valid requester at or above rr_ptr, with wrap.
  // -------------------------------------------------------------------------
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    scan_sum  = '0;
    for (int unsigned k = 0; k < NREQ_U; k++) begin
      scan_sum = {1'b0, rr_ptr_q} + sum_t'(k);
      if (scan_sum >= sum_t'(NREQ_U)) begin
        scan_sum = scan_sum - sum_t'(NREQ_U);
      end
      if (!gnt_found && req_valid[scan_sum[IDW-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = scan_sum[IDW-1:0];
      end
    end
  end

  // Operand mux for the granted requester.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int unsigned i = 0; i < NREQ_U; i++) begin
      if (gnt_idx == IDW'(i)) begin
        sel_a = req_a[16*i +: 16];
        sel_b = req_b[16*i +: 16];
      end
    end
  end

  assign rr_next = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next state and handshake outputs
  // req_ready is gated by rst_n so every output reads 0 while reset is held,
  // even if requesters keep req_valid asserted.
  // -------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    fire      = 1'b0;
    capture   = 1'b0;
    retire    = 1'b0;
    busy      = (state_q != S_IDLE);
    unique case (state_q)
      S_IDLE: begin
        if (gnt_found && rst_n) begin
          req_ready[gnt_idx] = 1'b1;
          fire               = 1'b1;
          state_d            = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd1) begin
          capture = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_valid && rsp_ready) begin
          retire  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q  <= '0;
      id_q      <= '0;
      cnt_q     <= '0;
      core_a    <= '0;
      core_b    <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_sign  <= 1'b0;
      rsp_exp   <= '0;
      rsp_frac  <= '0;
    end else begin
      if (fire) begin
        core_a   <= sel_a;
        core_b   <= sel_b;
        id_q     <= gnt_idx;
        rr_ptr_q <= rr_next;
        cnt_q    <= LAT_W;
      end else if (state_q == S_WAIT) begin
        cnt_q <= cnt_q - 4'd1;
      end

      if (capture) begin
        rsp_valid <= 1'b1;
        rsp_id    <= id_q;
        rsp_sign  <= core_sign;
        rsp_exp   <= core_exp;
        rsp_frac  <= core_frac;
      end else if (retire) begin
        rsp_valid <= 1'b0;
      end
    end
  end

`ifdef HALF_MUL_ARB_STATS_EN
  // Per-requester accepted-request counters; wrap naturally at 16 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt <= '0;
    end else if (fire) begin
      for (int unsigned i = 0; i < NREQ_U; i++) begin
        if (gnt_idx == IDW'(i)) begin
          grant_cnt[16*i +: 16] <= grant_cnt[16*i +: 16] + 16'd1;
        end
      end
    end
  end
`endif

  // -------------------------------------------------------------------------
  // Protocol properties
  // -------------------------------------------------------------------------
  a_ready_onehot0: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(req_ready));

  a_rsp_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (rsp_valid && !rsp_ready) |=>
      (rsp_valid && $stable({rsp_id, rsp_sign, rsp_exp, rsp_frac})));

endmodule
